// File: rtl/gen_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM encoding and hold counter sizing.
package gen_rr_arbiter_pkg;

    // Hold counter width; the counter saturates at its all-ones value.
    localparam int HOLD_CNT_W = 16;
    localparam logic [HOLD_CNT_W-1:0] HOLD_CNT_MAX = '1;

    // Arbiter FSM encoding: IDLE = 0, BUSY = 1.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/gen_rr_pick.sv
// Combinational round-robin winner search.
// Scans ptr, ptr+1, ..., N-1 first (masked encoder), then falls back to 0..N-1
// (unmasked encoder). Together these cover the wrapped scan order without a
// power-of-two lane count.
module gen_rr_pick #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] m_hit;
    logic [N-1:0] u_hit;
    logic [N:0]   m_seen;
    logic [N:0]   u_seen;
    logic [N-1:0] hit;

    assign m_seen[0] = 1'b0;
    assign u_seen[0] = 1'b0;

    // Per-lane masking and first-one detection for both encoders.
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign mask[i]     = (i >= int'(ptr));
        assign masked[i]   = req[i] & mask[i];
        assign m_hit[i]    = masked[i] & ~m_seen[i];
        assign m_seen[i+1] = m_seen[i] | masked[i];
        assign u_hit[i]    = req[i] & ~u_seen[i];
        assign u_seen[i+1] = u_seen[i] | req[i];
    end

    // Lanes at or above ptr take precedence; otherwise wrap to the lowest request.
    assign hit = m_seen[N] ? m_hit : u_hit;
    assign any = u_seen[N];

    // Encode the single hot winner into an index.
    always_comb begin
        idx = '0;
        for (int k = 0; k < N; k++) begin
            if (hit[k]) idx = IDX_W'(k);
        end
    end

endmodule

// File: rtl/gen_rr_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters.
// Handshake: a lane owns the resource while grant[lane] is high; it gives it up
// by pulsing done or dropping its req. Requests are sampled only in IDLE, and a
// grant is followed by at least one all-zero cycle before the next one.
// A grant held for MAX_HOLD cycles is force-released and flagged with timeout.
module gen_rr_arbiter
    import gen_rr_arbiter_pkg::*;
#(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout,
    output arb_state_e       state_dbg
);

    localparam logic [HOLD_CNT_W-1:0] MAX_HOLD_C = HOLD_CNT_W'(MAX_HOLD);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(N - 1);

    arb_state_e              state_q,       state_d;
    logic [N-1:0]            grant_q,       grant_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]        grant_idx_q,   grant_idx_d;
    logic                    timeout_q,     timeout_d;
    logic [IDX_W-1:0]        ptr_q,         ptr_d;
    logic [HOLD_CNT_W-1:0]   hold_cnt_q,    hold_cnt_d;

    logic                    pick_any;
    logic [IDX_W-1:0]        pick_idx;
    logic [N-1:0]            pick_onehot;
    logic                    rel_normal;
    logic                    rel_limit;

    gen_rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // One-hot decode of the winning index.
    for (genvar i = 0; i < N; i++) begin : g_onehot
        assign pick_onehot[i] = (pick_idx == IDX_W'(i));
    end

    // The owner is the lane recorded in grant_idx while BUSY.
    assign rel_normal = done | ~req[grant_idx_q];
    assign rel_limit  = (MAX_HOLD != 0) && (hold_cnt_q == MAX_HOLD_C);

    // Next-state and next-output logic for the grant FSM.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        timeout_d     = 1'b0;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d       = ST_BUSY;
                    grant_d       = pick_onehot;
                    grant_valid_d = 1'b1;
                    grant_idx_d   = pick_idx;
                    hold_cnt_d    = HOLD_CNT_W'(1);
                end
            end
            ST_BUSY: begin
                if (rel_normal || rel_limit) begin
                    state_d       = ST_IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    // Flag only a pure hold-limit release.
                    timeout_d     = ~rel_normal;
                    // Explicit wrap so N need not be a power of two.
                    ptr_d         = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);
                end else if (hold_cnt_q != HOLD_CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
                end
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            timeout_q     <= 1'b0;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            timeout_q     <= timeout_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign timeout     = timeout_q;
    assign state_dbg   = state_q;

endmodule
